lsu_mem_port: RTL and testbench

Load/store initiator that drives the byte-addressable data memory from the execute stage. It accepts one byte, halfword or word load/store request at a time over a valid/ready handshake. It issues word-aligned read/write cycles on the memory's addr/data/read_en/write_en interface, performing read-modify-write for sub-word stores. It returns the extended load data, or a misalignment error, as a one-cycle response pulse.

---
 rtl/lsu_mem_port_if.sv | 38 +++
 rtl/lsu_mem_port.sv | 121 ++++++++++++
 tb/tb_lsu_mem_port.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_port_if.sv
// Request/response handshake plus word-aligned memory bus between the execute
// stage, the load/store port and the data memory.
interface lsu_mem_port_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [1:0]        req_size_i;
  logic              req_unsigned_i;
  logic [AWIDTH-1:0] req_addr_i;
  logic [DWIDTH-1:0] req_wdata_i;
  logic              resp_valid_o;
  logic [DWIDTH-1:0] resp_rdata_o;
  logic              resp_err_o;
  logic [AWIDTH-1:0] mem_addr_o;
  logic [DWIDTH-1:0] mem_data_o;
  logic              mem_read_en_o;
  logic              mem_write_en_o;
  logic [DWIDTH-1:0] mem_data_i;

  // Load/store port side.
  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i,
           req_wdata_i, mem_data_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o
  );

  // Requester and memory side.
  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i,
           req_wdata_i, mem_data_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o
  );
endinterface

// File: rtl/lsu_mem_port.sv
// Single-outstanding load/store initiator: byte/half/word accesses mapped onto
// word-aligned memory cycles, with read-modify-write for sub-word stores.
module lsu_mem_port #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    lsu_mem_port_if.slave  bus
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOAD     = 3'd1;
    localparam logic [2:0] RMW_RD   = 3'd2;
    localparam logic [2:0] STORE_WR = 3'd3;
    localparam logic [2:0] RESP     = 3'd4;

    logic [2:0]        state;
    logic              we, uns, err;
    logic [1:0]        size, off;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] wdata, merge, rdata;
    logic [DWIDTH-1:0] shifted, ld_data, mg_data;
    logic              accept, bad, mem_active;

    assign off    = addr[1:0];
    assign accept = bus.req_valid_i & bus.req_ready_o;
    assign bad    = (bus.req_size_i == 2'b11) ||
                    (bus.req_size_i == 2'b01 && bus.req_addr_i[0]) ||
                    (bus.req_size_i == 2'b10 && bus.req_addr_i[1:0] != 2'b00);

    // Load path: bring the addressed lane to bit 0, then truncate and extend.
    assign shifted = bus.mem_data_i >> {off, 3'b000};
    always_comb begin
        ld_data = shifted;
        case (size)
            2'b00: ld_data = uns ? {{(DWIDTH-8){1'b0}}, shifted[7:0]}
                                 : {{(DWIDTH-8){shifted[7]}}, shifted[7:0]};
            2'b01: ld_data = uns ? {{(DWIDTH-16){1'b0}}, shifted[15:0]}
                                 : {{(DWIDTH-16){shifted[15]}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

    // Sub-word store: splice the new byte/half into the word just read.
    always_comb begin
        mg_data = bus.mem_data_i;
        if (size == 2'b00) begin
            case (off)
                2'd0: mg_data[7:0]   = wdata[7:0];
                2'd1: mg_data[15:8]  = wdata[7:0];
                2'd2: mg_data[23:16] = wdata[7:0];
                default: mg_data[31:24] = wdata[7:0];
            endcase
        end else if (off[1]) begin
            mg_data[31:16] = wdata[15:0];
        end else begin
            mg_data[15:0] = wdata[15:0];
        end
    end

    // Memory strobes decode straight from state so an async reset kills them at once.
    assign mem_active         = (state == LOAD) || (state == RMW_RD) || (state == STORE_WR);
    assign bus.mem_addr_o     = mem_active ? {addr[AWIDTH-1:2], 2'b00} : '0;
    assign bus.mem_read_en_o  = (state == LOAD) || (state == RMW_RD);
    assign bus.mem_write_en_o = (state == STORE_WR);
    assign bus.mem_data_o     = (state != STORE_WR) ? '0 : (size == 2'b10) ? wdata : merge;
    assign bus.req_ready_o    = rst & (state == IDLE);
    assign bus.resp_valid_o   = (state == RESP);
    assign bus.resp_rdata_o   = rdata;
    assign bus.resp_err_o     = err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            we    <= 1'b0;
            uns   <= 1'b0;
            size  <= 2'b00;
            addr  <= '0;
            wdata <= '0;
            merge <= '0;
            rdata <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    we    <= bus.req_we_i;
                    uns   <= bus.req_unsigned_i;
                    size  <= bus.req_size_i;
                    addr  <= bus.req_addr_i;
                    wdata <= bus.req_wdata_i;
                    if (bad) begin
                        rdata <= '0;
                        err   <= 1'b1;
                        state <= RESP;
                    end else if (!bus.req_we_i) begin
                        state <= LOAD;
                    end else if (bus.req_size_i == 2'b10) begin
                        state <= STORE_WR;
                    end else begin
                        state <= RMW_RD;
                    end
                end
                LOAD: begin
                    rdata <= ld_data;
                    err   <= 1'b0;
                    state <= RESP;
                end
                RMW_RD: begin
                    merge <= mg_data;
                    state <= STORE_WR;
                end
                STORE_WR: begin
                    rdata <= '0;
                    err   <= 1'b0;
                    state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench: a driver pushes expected responses into a scoreboard queue
// while an independent monitor pops and checks every response pulse.
module tb_lsu_mem_port;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   nchecks = 0;
    int   nerr = 0;
    int   rd_cnt = 0, wr_cnt = 0, en_cnt = 0;
    logic [31:0] last_wdata = '0;
    logic [31:0] mem [0:15];
    exp_t q[$];

    lsu_mem_port_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

    lsu_mem_port #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Tiny memory: words aliased on addr[5:2], combinational read, write on edge.
    assign bus.mem_data_i = mem[bus.mem_addr_o[5:2]];
    always @(posedge clk) if (bus.mem_write_en_o) mem[bus.mem_addr_o[5:2]] <= bus.mem_data_o;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_read_en_o) rd_cnt++;
        if (bus.mem_write_en_o) begin
            wr_cnt++;
            last_wdata = bus.mem_data_o;
        end
        if (bus.mem_read_en_o | bus.mem_write_en_o) en_cnt++;
        if (bus.mem_read_en_o & bus.mem_write_en_o) chk("rd_wr_overlap", 32'd1, 32'd0);
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (bus.resp_valid_o) begin
            if (q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("resp_rdata", bus.resp_rdata_o, e.rdata);
                chk("resp_err", {31'd0, bus.resp_err_o}, {31'd0, e.err});
                chk("resp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic drive(input logic we, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd);
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = we;
        bus.req_size_i     = sz;
        bus.req_unsigned_i = u;
        bus.req_addr_i     = a;
        bus.req_wdata_i    = wd;
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee, input int lat);
        int n;
        exp_t e;
        @(negedge clk);
        drive(we, sz, u, a, wd);
        n = 0;
        while (!bus.req_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready_o) chk("ready_timeout", 32'd0, 32'd1);
        e.rdata = er; e.err = ee; e.cyc = cyc + lat;
        q.push_back(e);
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("resp_timeout", q.size(), 32'd0);
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int a, rd0, wr0, en0;
        exp_t e;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'h8899AABB;
        bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_size_i = 2'b00;
        bus.req_unsigned_i = 1'b0; bus.req_addr_i = '0; bus.req_wdata_i = '0;

        repeat (2) @(negedge clk);
        chk("rst_resp_valid", {31'd0, bus.resp_valid_o}, 32'd0);
        chk("rst_rdata", bus.resp_rdata_o, 32'd0);
        chk("rst_err", {31'd0, bus.resp_err_o}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
        chk("rst_mem_en", {30'd0, bus.mem_read_en_o, bus.mem_write_en_o}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, bus.req_ready_o}, 32'd1);

        // Loads with sign/zero extension.
        issue(0, 2'b00, 0, 32'h01000002, 0, 32'hFFFFFF99, 0, 2);
        issue(0, 2'b00, 1, 32'h01000002, 0, 32'h00000099, 0, 2);
        issue(0, 2'b01, 0, 32'h01000000, 0, 32'hFFFFAABB, 0, 2);
        issue(0, 2'b01, 1, 32'h01000000, 0, 32'h0000AABB, 0, 2);
        issue(0, 2'b00, 0, 32'h01000003, 0, 32'hFFFFFF88, 0, 2);
        issue(0, 2'b10, 0, 32'h01000000, 0, 32'h8899AABB, 0, 2);
        drain();

        // Halfword store: one read, one merged write, response at cycle 3.
        rd0 = rd_cnt; wr0 = wr_cnt;
        issue(1, 2'b01, 0, 32'h01000002, 32'h00001234, 32'h0, 0, 3);
        drain();
        chk("sh_reads", rd_cnt - rd0, 32'd1);
        chk("sh_writes", wr_cnt - wr0, 32'd1);
        chk("sh_wdata", last_wdata, 32'h1234AABB);
        issue(0, 2'b10, 0, 32'h01000000, 0, 32'h1234AABB, 0, 2);
        drain();

        // Word store with a load held valid behind it.
        @(negedge clk);
        drive(1, 2'b10, 0, 32'h01000004, 32'hCAFEF00D);
        a = cyc;
        chk("sw_ready", {31'd0, bus.req_ready_o}, 32'd1);
        e.rdata = 32'h0; e.err = 1'b0; e.cyc = a + 2;
        q.push_back(e);
        @(posedge clk);
        #1 drive(0, 2'b10, 0, 32'h01000004, 32'h0);
        @(negedge clk);
        chk("held_ready_c1", {31'd0, bus.req_ready_o}, 32'd0);
        @(negedge clk);
        chk("held_ready_c2", {31'd0, bus.req_ready_o}, 32'd0);
        @(negedge clk);
        chk("held_ready_c3", {31'd0, bus.req_ready_o}, 32'd1);
        e.rdata = 32'hCAFEF00D; e.err = 1'b0; e.cyc = a + 5;
        q.push_back(e);
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
        drain();

        // Misaligned and illegal-size requests never touch memory.
        en0 = en_cnt;
        issue(0, 2'b10, 0, 32'h01000001, 0, 32'h0, 1, 1);
        issue(0, 2'b01, 0, 32'h01000003, 0, 32'h0, 1, 1);
        issue(1, 2'b11, 0, 32'h01000000, 32'hFFFFFFFF, 32'h0, 1, 1);
        drain();
        chk("err_no_mem_en", en_cnt - en0, 32'd0);

        // Reset during STORE_WR of a byte store aborts the write and the response.
        @(negedge clk);
        drive(1, 2'b00, 0, 32'h01000001, 32'h000000FF);
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_in_store_wr", {31'd0, bus.mem_write_en_o}, 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_we", {31'd0, bus.mem_write_en_o}, 32'd0);
        chk("abort_re", {31'd0, bus.mem_read_en_o}, 32'd0);
        chk("abort_addr", bus.mem_addr_o, 32'd0);
        chk("abort_data", bus.mem_data_o, 32'd0);
        chk("abort_resp_valid", {31'd0, bus.resp_valid_o}, 32'd0);
        chk("abort_rdata", bus.resp_rdata_o, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk("abort_mem_word", mem[0], 32'h1234AABB);
        issue(0, 2'b10, 0, 32'h01000000, 0, 32'h1234AABB, 0, 2);
        issue(0, 2'b00, 1, 32'h01000001, 0, 32'h000000AA, 0, 2);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
